// File: rtl/uart_io_buffer_pkg.sv
// -----------------------------------------------------------------------------
// uart_io_buffer_pkg
// Shared constants for the CPU-side UART byte buffer:
//   - default FIFO depth and pointer width
//   - MMIO register map of the UART window (control/status, RX data, TX data)
//   - bit positions inside the status word
//   - a helper that assembles the status word from the buffer flags
// -----------------------------------------------------------------------------
package uart_io_buffer_pkg;

    localparam int UART_DEPTH = 16;
    localparam int UART_AW    = 4;

    localparam logic [31:0] UART_CTRL_ADDR = 32'h8000_0000;
    localparam logic [31:0] UART_RX_ADDR   = 32'h8000_0004;
    localparam logic [31:0] UART_TX_ADDR   = 32'h8000_0008;

    localparam int STAT_TX_READY_BIT = 0;
    localparam int STAT_RX_VALID_BIT = 1;
    localparam int STAT_RX_OVF_BIT   = 2;

    // Status word as seen by a CPU load from UART_CTRL_ADDR.
    function automatic logic [31:0] uart_status_word(input logic tx_ready,
                                                     input logic rx_valid,
                                                     input logic rx_ovf);
        logic [31:0] w;
        w = '0;
        w[STAT_TX_READY_BIT] = tx_ready;
        w[STAT_RX_VALID_BIT] = rx_valid;
        w[STAT_RX_OVF_BIT]   = rx_ovf;
        return w;
    endfunction

endpackage

// File: rtl/uart_io_buffer_fifo.sv
// -----------------------------------------------------------------------------
// byte_fifo
// Show-ahead circular byte FIFO. The head byte is presented combinationally
// from the read pointer, so a consumer sees data the cycle after it is pushed.
// A push while full is accepted only when a pop happens in the same cycle
// (pop frees the slot first); a pop while empty is ignored.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push, din    write request and byte
//   pop          read request (removes head)
//   full, empty  occupancy flags
//   count        occupancy, AW+1 bits
//   head         current head byte (stale when empty)
// -----------------------------------------------------------------------------
module byte_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic [7:0]    head
);

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic w_full;
    logic w_empty;
    logic w_do_pop;
    logic w_do_push;

    assign w_full    = (r_count == FULL_CNT);
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = pop & ~w_empty;
    assign w_do_push = push & (~w_full | w_do_pop);

    // Storage is never reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign full  = w_full;
    assign empty = w_empty;
    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/uart_io_buffer.sv
// -----------------------------------------------------------------------------
// uart_io_buffer
// Byte buffer between the CPU's memory-mapped UART decode and the UART core.
// TX FIFO absorbs CPU store bursts and feeds the transmitter; RX FIFO holds
// received bytes until the CPU polls them. A sticky flag records any RX byte
// dropped because the RX FIFO was full.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   tx_wr_valid/tx_wr_data/tx_wr_ready  CPU -> TX FIFO
//   rx_rd/rx_valid/rx_data            CPU <- RX FIFO (rx_data is 0 when empty)
//   rx_ovf, ovf_clr                   sticky RX drop flag and its clear
//   tx_count, rx_count                FIFO occupancies
//   uart_din/_valid/_ready            TX FIFO -> UART transmitter
//   uart_dout/_valid/_ready           UART receiver -> RX FIFO
// -----------------------------------------------------------------------------
module uart_io_buffer
    import uart_io_buffer_pkg::*;
#(
    parameter int DEPTH = UART_DEPTH,
    parameter int AW    = UART_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tx_wr_valid,
    input  logic [7:0]    tx_wr_data,
    output logic          tx_wr_ready,
    input  logic          rx_rd,
    output logic          rx_valid,
    output logic [7:0]    rx_data,
    output logic          rx_ovf,
    input  logic          ovf_clr,
    output logic [AW:0]   tx_count,
    output logic [AW:0]   rx_count,
    output logic [7:0]    uart_din,
    output logic          uart_din_valid,
    input  logic          uart_din_ready,
    input  logic [7:0]    uart_dout,
    input  logic          uart_dout_valid,
    output logic          uart_dout_ready
);

    logic       w_tx_full;
    logic       w_tx_empty;
    logic       w_tx_push;
    logic [7:0] w_tx_head;

    logic       w_rx_full;
    logic       w_rx_empty;
    logic       w_rx_push;
    logic       w_rx_pop;
    logic       w_rx_drop;
    logic [7:0] w_rx_head;

    logic       r_dout_ready;
    logic       r_rx_ovf;

    // A full TX FIFO refuses the store outright, even if the UART drains the
    // head in the same cycle; this keeps tx_wr_ready a pure register decode.
    assign w_tx_push = tx_wr_valid & ~w_tx_full;

    byte_fifo #(.DEPTH(DEPTH), .AW(AW)) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_tx_push),
        .din   (tx_wr_data),
        .pop   (uart_din_ready),
        .full  (w_tx_full),
        .empty (w_tx_empty),
        .count (tx_count),
        .head  (w_tx_head)
    );

    // The receiver is always accepted once out of reset; a byte that finds
    // the FIFO full (and no CPU pop making room) is the one that is lost.
    assign w_rx_push = uart_dout_valid & r_dout_ready;
    assign w_rx_pop  = rx_rd & ~w_rx_empty;
    assign w_rx_drop = w_rx_push & w_rx_full & ~w_rx_pop;

    byte_fifo #(.DEPTH(DEPTH), .AW(AW)) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_rx_push),
        .din   (uart_dout),
        .pop   (rx_rd),
        .full  (w_rx_full),
        .empty (w_rx_empty),
        .count (rx_count),
        .head  (w_rx_head)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout_ready <= 1'b0;
            r_rx_ovf     <= 1'b0;
        end else begin
            r_dout_ready <= 1'b1;
            // A drop in the same cycle as a clear keeps the flag set.
            if (w_rx_drop) begin
                r_rx_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_rx_ovf <= 1'b0;
            end
        end
    end

    assign tx_wr_ready     = ~w_tx_full;
    assign uart_din        = w_tx_head;
    assign uart_din_valid  = ~w_tx_empty;
    assign rx_valid        = ~w_rx_empty;
    assign rx_data         = w_rx_empty ? 8'd0 : w_rx_head;
    assign rx_ovf          = r_rx_ovf;
    assign uart_dout_ready = r_dout_ready;

endmodule

// File: tb/tb_uart_io_buffer.sv
// -----------------------------------------------------------------------------
// tb_uart_io_buffer
// Scoreboard bench: bytes accepted into either FIFO are queued by the bench's
// own occupancy model and compared in order when the DUT hands them out.
// -----------------------------------------------------------------------------
module tb_uart_io_buffer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk;
    logic          rst_n;
    logic          tx_wr_valid;
    logic [7:0]    tx_wr_data;
    logic          tx_wr_ready;
    logic          rx_rd;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rx_ovf;
    logic          ovf_clr;
    logic [AW:0]   tx_count;
    logic [AW:0]   rx_count;
    logic [7:0]    uart_din;
    logic          uart_din_valid;
    logic          uart_din_ready;
    logic [7:0]    uart_dout;
    logic          uart_dout_valid;
    logic          uart_dout_ready;

    uart_io_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .tx_wr_valid     (tx_wr_valid),
        .tx_wr_data      (tx_wr_data),
        .tx_wr_ready     (tx_wr_ready),
        .rx_rd           (rx_rd),
        .rx_valid        (rx_valid),
        .rx_data         (rx_data),
        .rx_ovf          (rx_ovf),
        .ovf_clr         (ovf_clr),
        .tx_count        (tx_count),
        .rx_count        (rx_count),
        .uart_din        (uart_din),
        .uart_din_valid  (uart_din_valid),
        .uart_din_ready  (uart_din_ready),
        .uart_dout       (uart_dout),
        .uart_dout_valid (uart_dout_valid),
        .uart_dout_ready (uart_dout_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_vec;
    int         n_err;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic       m_ovf;
    logic [7:0] last_rx;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_status();
        chk("tx_count",        32'(tx_count),        32'(tx_q.size()));
        chk("rx_count",        32'(rx_count),        32'(rx_q.size()));
        chk("tx_wr_ready",     32'(tx_wr_ready),     32'(tx_q.size() < DEPTH));
        chk("rx_valid",        32'(rx_valid),        32'(rx_q.size() != 0));
        chk("rx_ovf",          32'(rx_ovf),          32'(m_ovf));
        chk("uart_din_valid",  32'(uart_din_valid),  32'(tx_q.size() != 0));
        chk("uart_dout_ready", 32'(uart_dout_ready), 32'(1));
        if (rx_q.size() == 0) begin
            chk("rx_data_empty", 32'(rx_data), 32'(0));
        end
    endtask

    // Called at a falling edge after the inputs for the next rising edge are
    // set: resolves this cycle's handshakes against the model, then advances.
    task automatic tick();
        int         tx_sz0;
        int         rx_sz0;
        logic       drop;
        logic [7:0] exp;
        #1;
        tx_sz0 = tx_q.size();
        rx_sz0 = rx_q.size();
        if (tx_sz0 > 0 && uart_din_ready) begin
            exp = tx_q.pop_front();
            chk("tx_byte", 32'(uart_din), 32'(exp));
            $display("tx drain  0x%02h (expected 0x%02h)", uart_din, exp);
        end
        if (tx_wr_valid) begin
            chk("tx_accept", 32'(tx_wr_ready), 32'(tx_sz0 < DEPTH));
            if (tx_sz0 < DEPTH) begin
                tx_q.push_back(tx_wr_data);
            end
            $display("tx push   0x%02h accepted=%0d", tx_wr_data, tx_sz0 < DEPTH);
        end
        if (rx_rd && rx_sz0 > 0) begin
            exp = rx_q.pop_front();
            chk("rx_byte", 32'(rx_data), 32'(exp));
            last_rx = rx_data;
            $display("rx read   0x%02h (expected 0x%02h)", rx_data, exp);
        end
        drop = 1'b0;
        if (uart_dout_valid) begin
            if (rx_q.size() < DEPTH) begin
                rx_q.push_back(uart_dout);
            end else begin
                drop  = 1'b1;
                m_ovf = 1'b1;
            end
            $display("rx arrive 0x%02h dropped=%0d", uart_dout, drop);
        end
        if (ovf_clr && !drop) begin
            m_ovf = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        chk_status();
    endtask

    task automatic idle_inputs();
        tx_wr_valid     = 1'b0;
        rx_rd           = 1'b0;
        uart_dout_valid = 1'b0;
        ovf_clr         = 1'b0;
    endtask

    task automatic drain_tx();
        uart_din_ready = 1'b1;
        for (int k = 0; k < 4 * DEPTH && tx_q.size() > 0; k++) begin
            tick();
        end
        chk("tx_drain_done", 32'(tx_q.size()), 32'(0));
    endtask

    task automatic drain_rx();
        rx_rd = 1'b1;
        for (int k = 0; k < 4 * DEPTH && rx_q.size() > 0; k++) begin
            tick();
        end
        rx_rd = 1'b0;
        chk("rx_drain_done", 32'(rx_q.size()), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        m_ovf = 1'b0;
        last_rx = 8'h00;
        rst_n = 1'b1;
        tx_wr_data = 8'h00;
        uart_dout = 8'h00;
        uart_din_ready = 1'b0;
        idle_inputs();

        // 1. Reset asserted mid-cycle takes effect without a clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_tx_wr_ready", 32'(tx_wr_ready),    32'(1));
        chk("rst_rx_valid",    32'(rx_valid),       32'(0));
        chk("rst_rx_data",     32'(rx_data),        32'(0));
        chk("rst_din_valid",   32'(uart_din_valid), 32'(0));
        chk("rst_tx_count",    32'(tx_count),       32'(0));
        chk("rst_rx_count",    32'(rx_count),       32'(0));
        chk("rst_rx_ovf",      32'(rx_ovf),         32'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 2. TX burst into a stalled transmitter, overfill attempt, drain.
        uart_din_ready = 1'b0;
        tx_wr_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            tx_wr_data = 8'(8'h41 + i);
            tick();
        end
        chk("tx_full_count", 32'(tx_count),    32'(16));
        chk("tx_full_ready", 32'(tx_wr_ready), 32'(0));
        tx_wr_data = 8'h51;
        tick();
        tx_wr_valid = 1'b0;
        drain_tx();
        uart_din_ready = 1'b0;
        chk("tx_empty_count", 32'(tx_count), 32'(0));

        // 3. RX overflow: 17 bytes with no CPU reads, then read back and clear.
        uart_dout_valid = 1'b1;
        for (int i = 0; i <= DEPTH; i++) begin
            uart_dout = 8'(i);
            tick();
        end
        uart_dout_valid = 1'b0;
        chk("rx_ovf_count", 32'(rx_count), 32'(16));
        chk("rx_ovf_set",   32'(rx_ovf),   32'(1));
        drain_rx();
        chk("rx_last_ovf", 32'(last_rx), 32'(8'h0F));
        chk("rx_ovf_held", 32'(rx_ovf),  32'(1));
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("rx_ovf_clr", 32'(rx_ovf), 32'(0));

        // 4. Full RX FIFO with simultaneous pop and arrival: nothing lost.
        uart_dout_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            uart_dout = 8'(8'h20 + i);
            tick();
        end
        uart_dout = 8'hAA;
        rx_rd = 1'b1;
        tick();
        uart_dout_valid = 1'b0;
        rx_rd = 1'b0;
        chk("rx_popush_count", 32'(rx_count), 32'(16));
        chk("rx_popush_ovf",   32'(rx_ovf),   32'(0));
        drain_rx();
        chk("rx_last_aa", 32'(last_rx), 32'(8'hAA));

        // Set beats clear when a drop and ovf_clr coincide.
        uart_dout_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            uart_dout = 8'(8'h60 + i);
            tick();
        end
        uart_dout = 8'h77;
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        uart_dout_valid = 1'b0;
        chk("rx_set_wins", 32'(rx_ovf), 32'(1));
        drain_rx();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;

        // 5. Interleaved push/pop across the pointer wrap on both FIFOs.
        tx_wr_valid = 1'b1;
        uart_dout_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tx_wr_data = 8'(8'h90 + i);
            uart_dout  = 8'(8'hC0 + i);
            tick();
        end
        uart_din_ready = 1'b1;
        rx_rd = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tx_wr_data = 8'($urandom_range(0, 255));
            uart_dout  = 8'($urandom_range(0, 255));
            tick();
        end
        tx_wr_valid = 1'b0;
        uart_dout_valid = 1'b0;
        chk("wrap_tx_count", 32'(tx_count), 32'(3));
        chk("wrap_rx_count", 32'(rx_count), 32'(3));
        drain_rx();
        drain_tx();

        // 6. Reset while the transmitter is stalled with 5 queued bytes.
        uart_din_ready = 1'b0;
        tx_wr_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tx_wr_data = 8'(8'hE0 + i);
            tick();
        end
        tx_wr_valid = 1'b0;
        chk("pre_rst_tx_count", 32'(tx_count), 32'(5));
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_din_valid", 32'(uart_din_valid), 32'(0));
        chk("mid_rst_tx_count",  32'(tx_count),       32'(0));
        chk("mid_rst_tx_ready",  32'(tx_wr_ready),    32'(1));
        tx_q.delete();
        rx_q.delete();
        m_ovf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        uart_din_ready = 1'b1;
        repeat (6) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
